// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock monitor and its users.
package clk_mon_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned ERR_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_LOST    = 3'd4
    } mon_state_e;

    // A period is good when it lies within tol cycles of the expected value.
    function automatic logic period_good(input int unsigned p,
                                         input int unsigned exp_div,
                                         input int unsigned tol);
        int unsigned diff;
        diff = (p >= exp_div) ? (p - exp_div) : (exp_div - p);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of an asynchronous divided clock against an
// expected ratio, and tracks lock, loss of clock and out-of-tolerance errors.
module clock_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned EXP_DIV  = 2,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 256,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clk_mon,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned      RUN_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    mon_state_e       state, state_nxt;
    logic             mon_s, mon_d, rise, fall;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] high_cap, high_cap_nxt;
    logic [CNT_W-1:0] period_nxt, high_time_nxt;
    logic [RUN_W-1:0] good_run, good_run_nxt;
    logic [ERR_W-1:0] err_count_nxt;
    logic             period_valid_nxt, err_pulse_nxt, locked_nxt, lost_nxt;
    logic             timeout, good, measuring, meas_pulse;

    sync_2ff u_sync (
        .clk   (clk_in),
        .rst_n (rst_n),
        .d     (clk_mon),
        .q     (mon_s)
    );

    // Registered edge detect on the synchronized level.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mon_d <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            mon_d <= mon_s;
            rise  <= mon_s & ~mon_d;
            fall  <= ~mon_s & mon_d;
        end
    end

    // cnt doubles as the period counter and the since-last-rise timeout counter.
    assign timeout    = (32'(cnt) >= TIMEOUT);
    assign good       = period_good(32'(cnt), EXP_DIV, TOL);
    assign measuring  = (state == ST_MEASURE) || (state == ST_LOCKED);
    assign meas_pulse = enable && measuring && rise && !timeout;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_ACQUIRE;
                ST_ACQUIRE: if (rise) state_nxt = ST_MEASURE;
                ST_MEASURE: begin
                    if (timeout) begin
                        state_nxt = ST_LOST;
                    end else if (meas_pulse && good &&
                                 (good_run == RUN_W'(LOCK_CNT - 1))) begin
                        state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (timeout) begin
                        state_nxt = ST_LOST;
                    end else if (meas_pulse && !good) begin
                        state_nxt = ST_MEASURE;
                    end
                end
                ST_LOST:    if (rise) state_nxt = ST_ACQUIRE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_nxt          = cnt;
        high_cap_nxt     = high_cap;
        good_run_nxt     = good_run;
        period_nxt       = period;
        high_time_nxt    = high_time;
        err_count_nxt    = err_count;
        locked_nxt       = locked;
        lost_nxt         = lost;
        period_valid_nxt = meas_pulse;
        err_pulse_nxt    = meas_pulse && !good;

        // IDLE clears the counters but leaves published results and flags alone.
        if (state_nxt == ST_IDLE) begin
            cnt_nxt      = '0;
            high_cap_nxt = '0;
            good_run_nxt = '0;
        end else begin
            locked_nxt = (state_nxt == ST_LOCKED);
            lost_nxt   = (state_nxt == ST_LOST);
            if (rise) begin
                cnt_nxt = CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
            if (fall) begin
                high_cap_nxt = cnt;
            end
            if (meas_pulse) begin
                period_nxt    = cnt;
                high_time_nxt = high_cap;
                if (!good) begin
                    good_run_nxt = '0;
                end else if (good_run != RUN_W'(LOCK_CNT)) begin
                    good_run_nxt = good_run + RUN_W'(1);
                end
            end
            if (!((state_nxt == ST_MEASURE) || (state_nxt == ST_LOCKED))) begin
                good_run_nxt = '0;
            end
        end

        if (err_pulse_nxt && (err_count != ERR_MAX)) begin
            err_count_nxt = err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            high_cap     <= '0;
            good_run     <= '0;
            period       <= '0;
            high_time    <= '0;
            err_count    <= '0;
            period_valid <= 1'b0;
            err_pulse    <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            high_cap     <= high_cap_nxt;
            good_run     <= good_run_nxt;
            period       <= period_nxt;
            high_time    <= high_time_nxt;
            err_count    <= err_count_nxt;
            period_valid <= period_valid_nxt;
            err_pulse    <= err_pulse_nxt;
            locked       <= locked_nxt;
            lost         <= lost_nxt;
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Randomized self-checking bench for clock_monitor with a timestamp-based
// reference model plus directed lock / error / loss / reset scenarios.
module tb_clock_monitor;

    localparam int EXP_DIV  = 4;
    localparam int TOL      = 0;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 256;
    localparam int CNT_W    = 16;
    localparam int LAT      = 3;

    logic             clk_in  = 1'b0;
    logic             rst_n   = 1'b0;
    logic             clk_mon = 1'b0;
    logic             enable  = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             lost;
    logic             err_pulse;
    logic [7:0]       err_count;

    int n_chk  = 0;
    int n_pass = 0;

    clock_monitor #(
        .EXP_DIV  (EXP_DIV),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .clk_mon      (clk_mon),
        .enable       (enable),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost),
        .err_pulse    (err_pulse),
        .err_count    (err_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: every rise/fall of clk_mon takes effect LAT edges after
    // the edge that first samples it; periods are differences of rise stamps.
    typedef enum int {P_IDLE, P_ACQ, P_RUN, P_LOST} phase_e;

    phase_e ph;
    int     k, last_rise, hcap;
    bit     smp [0:LAT+1];
    int     m_period, m_high, m_err_count, m_good_run;
    bit     m_pv, m_err, m_locked, m_lost;

    task automatic model_step();
        bit r_e, f_e;
        int per, diff;
        if (!rst_n) begin
            for (int i = 0; i <= LAT + 1; i++) smp[i] = 1'b0;
            ph = P_IDLE; k = 0; last_rise = 0; hcap = 0;
            m_period = 0; m_high = 0; m_err_count = 0; m_good_run = 0;
            m_pv = 0; m_err = 0; m_locked = 0; m_lost = 0;
            return;
        end
        k++;
        for (int i = LAT + 1; i > 0; i--) smp[i] = smp[i-1];
        smp[0] = clk_mon;
        r_e  = smp[LAT] && !smp[LAT+1];
        f_e  = !smp[LAT] && smp[LAT+1];
        m_pv = 0;
        m_err = 0;
        if (!enable) begin
            ph = P_IDLE;
            m_good_run = 0;
            hcap = 0;
            return;
        end
        case (ph)
            P_IDLE: begin
                ph = P_ACQ; m_locked = 0; m_lost = 0;
            end
            P_ACQ: if (r_e) begin
                ph = P_RUN; last_rise = k;
            end
            P_RUN: begin
                if (f_e) hcap = k - last_rise;
                if (k - last_rise >= TIMEOUT) begin
                    ph = P_LOST; m_lost = 1; m_locked = 0; m_good_run = 0;
                end else if (r_e) begin
                    per = k - last_rise;
                    last_rise = k;
                    m_pv = 1; m_period = per; m_high = hcap;
                    diff = (per > EXP_DIV) ? per - EXP_DIV : EXP_DIV - per;
                    if (diff <= TOL) begin
                        m_good_run++;
                        if (m_good_run >= LOCK_CNT) m_locked = 1;
                    end else begin
                        m_err = 1; m_good_run = 0; m_locked = 0;
                        if (m_err_count < 255) m_err_count++;
                    end
                end
            end
            P_LOST: if (r_e) begin
                ph = P_ACQ; m_lost = 0;
            end
            default: ph = P_IDLE;
        endcase
    endtask

    initial forever begin
        @(posedge clk_in or negedge rst_n);
        model_step();
    end

    // Continuous comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk_in);
        check_eq("m_period_valid", period_valid, m_pv);
        check_eq("m_err_pulse", err_pulse, m_err);
        check_eq("m_locked", locked, m_locked);
        check_eq("m_lost", lost, m_lost);
        check_eq("m_err_count", err_count, m_err_count);
        check_eq("m_period", period, m_period);
        check_eq("m_high_time", high_time, m_high);
    end

    task automatic drive_period(input int hi, input int lo);
        clk_mon = 1'b1;
        repeat (hi) @(negedge clk_in);
        clk_mon = 1'b0;
        repeat (lo) @(negedge clk_in);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_period"}, period, 0);
        check_eq({tag, "_high_time"}, high_time, 0);
        check_eq({tag, "_period_valid"}, period_valid, 0);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_lost"}, lost, 0);
        check_eq({tag, "_err_pulse"}, err_pulse, 0);
        check_eq({tag, "_err_count"}, err_count, 0);
    endtask

    initial begin
        int hi, lo;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");

        // Divide-by-4 stream: ACQUIRE rise plus four measured periods to lock.
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (4) drive_period(2, 2);
        check_eq("prelock_pv", period_valid, 1);
        check_eq("prelock_locked", locked, 0);
        drive_period(2, 2);
        check_eq("lock_pv", period_valid, 1);
        check_eq("lock_locked", locked, 1);
        check_eq("lock_period", period, 4);
        check_eq("lock_high", high_time, 2);

        // One 6-cycle period injected into a locked stream.
        drive_period(2, 2);
        drive_period(3, 3);
        drive_period(2, 2);
        check_eq("inj_period", period, 6);
        check_eq("inj_high", high_time, 3);
        check_eq("inj_err_pulse", err_pulse, 1);
        check_eq("inj_err_count", err_count, 1);
        check_eq("inj_locked", locked, 0);
        repeat (3) drive_period(2, 2);
        check_eq("relock_3_locked", locked, 0);
        drive_period(2, 2);
        check_eq("relock_4_locked", locked, 1);
        check_eq("relock_err_pulse", err_pulse, 0);

        // clk_mon stuck low past the timeout, then restarted.
        clk_mon = 1'b0;
        repeat (TIMEOUT + 4) @(negedge clk_in);
        check_eq("stuck_lost", lost, 1);
        check_eq("stuck_locked", locked, 0);
        drive_period(2, 2);
        check_eq("restart_lost", lost, 0);
        check_eq("restart_pv", period_valid, 0);

        // Random periods with occasional enable drops.
        repeat (120) begin
            if ($urandom_range(0, 99) < 65) begin
                hi = 2; lo = 2;
            end else begin
                hi = $urandom_range(1, 4);
                lo = $urandom_range(1, 4);
            end
            drive_period(hi, lo);
            if ($urandom_range(0, 19) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk_in);
                enable = 1'b1;
            end
        end

        // Enable dropped while locked holds the flag; re-enable reacquires.
        repeat (6) drive_period(2, 2);
        check_eq("en_prelock_locked", locked, 1);
        enable = 1'b0;
        repeat (3) @(negedge clk_in);
        check_eq("en_off_locked", locked, 1);
        check_eq("en_off_pv", period_valid, 0);
        enable = 1'b1;
        drive_period(2, 2);
        check_eq("en_on_locked", locked, 0);

        // Reset pulsed in the middle of a period.
        clk_mon = 1'b1;
        repeat (2) @(negedge clk_in);
        clk_mon = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk_in);
        check_all_zero("midrst");
        rst_n = 1'b1;
        drive_period(2, 2);
        check_eq("midrst_first_pv", period_valid, 0);
        drive_period(2, 2);
        check_eq("midrst_second_pv", period_valid, 1);
        check_eq("midrst_period", period, 4);

        // Error counter saturation.
        repeat (300) drive_period(3, 3);
        check_eq("sat_err_count", err_count, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
